line_pixel_serializer: RTL

//  Downstream consumer of the frame-buffer stage. Fetches one line (LINE_PIX pixels) at a time:

---
 rtl/display_pkg.sv | 27 ++
 rtl/pixel_pos_counter.sv | 35 +++
 rtl/line_pixel_serializer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Display pipeline shared definitions: pixel and line geometry,
// counter widths and the line-fetch state encoding.
package display_pkg;

    localparam int PIX_W     = 8;
    localparam int LINE_PIX  = 330;
    localparam int NUM_LINES = 110;
    localparam int LINE_W    = PIX_W * LINE_PIX;
    localparam int CNT_W     = 10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetchState_e;

    // Increment with wrap back to zero after lim-1.
    function automatic logic [CNT_W-1:0] wrapInc(
        input logic [CNT_W-1:0] v,
        input int               lim
    );
        if (v == CNT_W'(lim - 1))
            return '0;
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Column/row position of the pixel currently presented downstream.
// Ports: clk, reset; advance (pixel accepted), valid (pixel present);
// col/row position; sof/eol markers qualified by valid.
module pixel_pos_counter
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             valid,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             sof,
    output logic             eol
);

    logic lastCol;

    assign lastCol = (col == CNT_W'(LINE_PIX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            col <= wrapInc(col, LINE_PIX);
            if (lastCol)
                row <= wrapInc(row, NUM_LINES);
        end
    end

    assign sof = valid && (col == '0) && (row == '0);
    assign eol = valid && lastCol;

endmodule

// File: rtl/line_pixel_serializer.sv
// Fetches whole lines from the frame buffer and streams them out
// one pixel per accepted transfer, with a prefetching shadow line.
// Ports: clk, reset (async, high), enable;
// line_req/req_line/line_data_in to the frame buffer;
// px_valid/px_ready/px_data/px_col/px_row/sof/eol downstream;
// underrun sticky flag.
module line_pixel_serializer
    import display_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             line_req,
    output logic [CNT_W-1:0] req_line,
    input  logic [0:LINE_W-1] line_data_in,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [PIX_W-1:0] px_data,
    output logic [CNT_W-1:0] px_col,
    output logic [CNT_W-1:0] px_row,
    output logic             sof,
    output logic             eol,
    output logic             underrun
);

    localparam int LAT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int LAST  = LOAD_LAT - 1;

    fetchState_e      state;
    fetchState_e      stateNext;
    logic [LAT_W-1:0] waitCnt;
    logic [LAT_W-1:0] waitCntNext;
    logic             capture;
    logic [CNT_W-1:0] fetchPtr;

    logic [0:LINE_W-1] shadow;
    logic              shadowFull;
    logic [0:LINE_W-1] active;
    logic [CNT_W-1:0]  activeLeft;

    logic accept;
    logic lastPix;
    logic load;

    // ---------------- fetch FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        line_req    = 1'b0;
        capture     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && !shadowFull)
                    stateNext = REQ;
            end
            REQ: begin
                line_req    = 1'b1;
                waitCntNext = '0;
                stateNext   = WAIT;
            end
            WAIT: begin
                if (waitCnt == LAT_W'(LAST)) begin
                    capture   = 1'b1;
                    stateNext = IDLE;
                end else begin
                    waitCntNext = waitCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetchPtr <= '0;
        else if (capture)
            fetchPtr <= wrapInc(fetchPtr, NUM_LINES);
    end

    assign req_line = fetchPtr;

    // ---------------- shadow line ----------------
    // Capture and load never coincide: load needs shadowFull,
    // capture only happens while the shadow is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            shadowFull <= 1'b0;
        end else begin
            if (load)
                shadowFull <= 1'b0;
            if (capture) begin
                shadow     <= line_data_in;
                shadowFull <= 1'b1;
            end
        end
    end

    // ---------------- active line / output ----------------
    assign px_valid = (activeLeft != '0);
    assign accept   = px_valid && px_ready;
    assign lastPix  = (activeLeft == CNT_W'(1));
    // Refill as soon as the last pixel leaves, so lines run gapless.
    assign load = shadowFull && (!px_valid || (accept && lastPix));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= '0;
            activeLeft <= '0;
            px_data    <= '0;
        end else if (load) begin
            active     <= shadow;
            activeLeft <= CNT_W'(LINE_PIX);
            px_data    <= shadow[0 +: PIX_W];
        end else if (accept) begin
            active     <= active << PIX_W;
            activeLeft <= activeLeft - 1'b1;
            if (!lastPix)
                px_data <= active[PIX_W +: PIX_W];
        end
    end

    pixel_pos_counter u_pos (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .valid   (px_valid),
        .col     (px_col),
        .row     (px_row),
        .sof     (sof),
        .eol     (eol)
    );

    // Starving the consumer at (0,0) is the normal start-up state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underrun <= 1'b0;
        else if (px_ready && !px_valid &&
                 (px_col != '0 || px_row != '0))
            underrun <= 1'b1;
    end

endmodule
